pattern_scan_ctrl: RTL
======================

Name: pattern_scan_ctrl

Overview:
Command-driven controller for the bit-serial pattern detectors. It accepts a scan command (pattern, length, overlap mode, frame length) through a start handshake. It then scans a frame of valid-qualified serial bits, pulses on each match and reports a saturating match count plus the index of the first match on completion. It sits between the configuration/host side and the serial data stream and replaces the fixed-pattern detector instances.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
LEN_W, 4, width of cfg_len_i; must satisfy 2**LEN_W > MAX_LEN
FRAME_W, 16, width of frame length and bit index
CNT_W, 8, width of match counter

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  command request; accepted only when ready_o=1
cfg_pattern_i  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
cfg_len_i  in  LEN_W  pattern length in bits
cfg_overlap_i  in  1  1=overlapping matches, 0=non-overlapping
cfg_frame_len_i  in  FRAME_W  number of valid bits to scan
abort_i  in  1  terminate the scan, return to IDLE
valid_i  in  1  d_i qualifier
d_i  in  1  serial data bit
ready_o  out  1  high in IDLE only
busy_o  out  1  high in SCAN
match_o  out  1  one-cycle pulse per detected match
done_o  out  1  one-cycle pulse on frame completion
match_cnt_o  out  CNT_W  matches in the current/last frame, saturating
first_vld_o  out  1  at least one match found in the frame
first_idx_o  out  FRAME_W  0-based index of the bit that completed the first match

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values: state=IDLE, ready_o=1, busy_o=0, match_o=0, done_o=0, match_cnt_o=0, first_vld_o=0, first_idx_o=0. History register, fill count and bit counter are all cleared.
- FSM has three states: IDLE, SCAN and DONE.
- IDLE:
  - start_i=1 latches all cfg_* inputs, clears the bit counter, fill, history, match_cnt_o, first_vld_o and first_idx_o, and moves to SCAN on the next edge.
  - valid_i is ignored in IDLE.
- SCAN:
  - Each cycle with valid_i=1 accepts d_i. The bit shifts into the history at bit 0, fill increments (saturating at MAX_LEN), and the bit counter increments.
  - A match occurs when all of these hold:
    - the latched len is in 1..MAX_LEN;
    - fill including the current bit is at least len;
    - history[len-1:0] including the current bit equals pattern[len-1:0].
  - On a match:
    - match_o pulses on the cycle after the accepting edge (latency 1).
    - match_cnt_o increments, saturating at 2**CNT_W-1.
    - On the first match, first_idx_o = index of the accepted bit and first_vld_o=1.
    - In non-overlap mode, fill clears to 0, so the next match needs len fresh bits. In overlap mode, fill is kept.
  - A latched len of 0 or greater than MAX_LEN never matches. The frame still runs to completion.
  - When the accepted bit is bit number frame_len-1, the FSM moves to DONE. A match on that last bit is still counted, and match_o coincides with done_o.
  - A latched frame_len of 0 moves SCAN to DONE on the first SCAN cycle without accepting any bit.
  - valid_i=0 holds all state.
  - start_i is ignored while not in IDLE.
- DONE: done_o=1 for exactly one cycle, ready_o=0, then IDLE. match_cnt_o, first_vld_o and first_idx_o hold until the next accepted start.
- abort_i:
  - Acts in SCAN or DONE and has priority over valid_i and completion.
  - Next state is IDLE, no done_o pulse, no match from that cycle's bit.
  - Results hold their partial values.
- Reset asserted mid-scan returns immediately to the reset values listed above.
- busy_o = (state==SCAN). All outputs are registered.

Test Plan:
- Overlap: pattern=4'b1011, len=4, overlap=1, frame=7, bits 1,0,1,1,0,1,1 -> match_o pulses after bits 3 and 6; done with match_cnt_o=2, first_idx_o=3, first_vld_o=1.
- Non-overlap: same stimulus with overlap=0 -> one match_o pulse (after bit 3); done with match_cnt_o=1, first_idx_o=3.
- Gaps and latency: pattern=3'b110, len=3, frame=5, valid_i toggling with bits 1,1,0,0,0 -> a single match_o exactly one cycle after the third accepted bit; done_o one cycle after the fifth accepted bit; cnt=1, idx=2.
- Saturation: CNT_W=8, pattern=1'b1, len=1, frame=300, all ones -> match_cnt_o=255, first_idx_o=0.
- Edge configs:
  - frame=0 -> done_o two cycles after start, cnt=0, first_vld_o=0.
  - len=0 with frame=4 of all zeros -> cnt=0.
  - start_i during SCAN -> ignored.
- Abort and reset:
  - abort_i after 2 of 7 bits -> IDLE, no done_o, ready_o=1.
  - rst_ni low mid-scan -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: command-driven serial pattern scanner reporting match pulses,
// a saturating match count and the index of the first match in each frame.
module pattern_scan_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int FRAME_W = 16,
    parameter int CNT_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [MAX_LEN-1:0] cfg_pattern_i,
    input  logic [LEN_W-1:0]   cfg_len_i,
    input  logic               cfg_overlap_i,
    input  logic [FRAME_W-1:0] cfg_frame_len_i,
    input  logic               abort_i,
    input  logic               valid_i,
    input  logic               d_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               match_o,
    output logic               done_o,
    output logic [CNT_W-1:0]   match_cnt_o,
    output logic               first_vld_o,
    output logic [FRAME_W-1:0] first_idx_o
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_t state, state_d;
    logic [MAX_LEN-1:0] pattern, hist, hist_n, mask;
    logic [LEN_W-1:0]   len, fill, fill_n;
    logic               overlap;
    logic [FRAME_W-1:0] frame_len, bit_cnt;
    logic               accept, last, hit;

    assign accept = state == SCAN && !abort_i && valid_i && frame_len != '0;
    assign last   = bit_cnt == frame_len - FRAME_W'(1);
    assign hist_n = {hist[MAX_LEN-2:0], d_i};
    assign fill_n = fill == MAX_LEN_L ? fill : fill + 1'b1;
    // lengths outside 1..MAX_LEN are rejected by the hit term, so the mask only matters in range
    assign mask   = ~({MAX_LEN{1'b1}} << len);
    assign hit    = accept && len != '0 && len <= MAX_LEN_L && fill_n >= len
                    && ((hist_n ^ pattern) & mask) == '0;

    always_comb begin
        state_d = state == IDLE ? (start_i ? SCAN : IDLE)
                : state == SCAN ? (abort_i ? IDLE
                                  : (frame_len == '0 || (accept && last)) ? DONE : SCAN)
                : IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_o     <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            match_o     <= 1'b0;
            match_cnt_o <= '0;
            first_vld_o <= 1'b0;
            first_idx_o <= '0;
            pattern     <= '0;
            len         <= '0;
            overlap     <= 1'b0;
            frame_len   <= '0;
            hist        <= '0;
            fill        <= '0;
            bit_cnt     <= '0;
        end else begin
            ready_o <= state_d == IDLE;
            busy_o  <= state_d == SCAN;
            done_o  <= state_d == DONE;
            match_o <= hit;
            if (state == IDLE && start_i) begin
                pattern     <= cfg_pattern_i;
                len         <= cfg_len_i;
                overlap     <= cfg_overlap_i;
                frame_len   <= cfg_frame_len_i;
                hist        <= '0;
                fill        <= '0;
                bit_cnt     <= '0;
                match_cnt_o <= '0;
                first_vld_o <= 1'b0;
                first_idx_o <= '0;
            end else if (accept) begin
                hist    <= hist_n;
                bit_cnt <= bit_cnt + FRAME_W'(1);
                fill    <= (hit && !overlap) ? '0 : fill_n;
                if (hit && match_cnt_o != '1) match_cnt_o <= match_cnt_o + 1'b1;
                if (hit && !first_vld_o) begin
                    first_vld_o <= 1'b1;
                    first_idx_o <= bit_cnt;
                end
            end
        end
    end
endmodule
